// File: rtl/r2r_dac_streamer.sv
// ---------------------------------------------------------------------------
// r2r_dac_streamer
//   Buffers DAC samples in a small FIFO and releases one per programmable
//   sample period, so an external R2R ladder updates at a fixed rate no
//   matter how bursty the producer is.
//
//   Optional feature macro: R2R_TRIANGLE_EN
//     defined   -> 'mode' port exists; mode=1 replaces FIFO playback with a
//                  +/-1 per tick triangle sweep over the full code range.
//     undefined -> stream mode only, no mode port, no triangle logic.
//
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   ena          sample timer enable (pushes are accepted regardless)
//   din          sample to enqueue, qualified by din_valid
//   din_ready    FIFO not full (registered occupancy only)
//   div          sample period minus 1, in clk cycles
//   dac_out      registered code to the ladder, midscale after reset
//   level        FIFO occupancy 0..DEPTH
//   underflow    sticky: a tick found the FIFO empty; cleared by clr_uf
//   mode         (R2R_TRIANGLE_EN only) 0 stream, 1 triangle
// ---------------------------------------------------------------------------
module r2r_dac_streamer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int DIV_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ena,
    input  logic [WIDTH-1:0]         din,
    input  logic                     din_valid,
    output logic                     din_ready,
    input  logic [DIV_W-1:0]         div,
    output logic [WIDTH-1:0]         dac_out,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     underflow,
`ifdef R2R_TRIANGLE_EN
    input  logic                     mode,
`endif
    input  logic                     clr_uf
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]      LVL_FULL = (AW+1)'(DEPTH);
    localparam logic [WIDTH-1:0] CODE_MID = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] CODE_MAX = '1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [DIV_W-1:0] cnt;
    logic             tick, push, pop, empty, stream;

    // ---------------- sample timer ----------------
    // '>=' rather than '==' so lowering div below the running count ticks on
    // the next enabled cycle instead of wrapping through the full range.
    assign tick = ena && (cnt >= div);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    cnt <= '0;
        else if (tick) cnt <= '0;
        else if (ena)  cnt <= cnt + DIV_W'(1);
    end

    // ---------------- FIFO ----------------
`ifdef R2R_TRIANGLE_EN
    assign stream = ~mode;
`else
    assign stream = 1'b1;
`endif

    assign empty     = (level == '0);
    assign din_ready = (level != LVL_FULL);   // from registered level only
    assign push      = din_valid && din_ready;
    // Emptiness is judged on pre-edge state, so a word pushed on a tick edge
    // into an empty FIFO is not popped until the following tick.
    assign pop       = tick && stream && !empty;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    // Pointers wrap naturally (DEPTH is a power of two); level tells full
    // from empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   level <= level + (AW+1)'(1);
                2'b01:   level <= level - (AW+1)'(1);
                default: level <= level;
            endcase
        end
    end

    // ---------------- underflow ----------------
    // A new underflow takes priority over a coincident clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                      underflow <= 1'b0;
        else if (tick && stream && empty) underflow <= 1'b1;
        else if (clr_uf)                 underflow <= 1'b0;
    end

    // ---------------- DAC output ----------------
`ifdef R2R_TRIANGLE_EN
    logic dir_up;
    logic step_up;

    // Flip at the endpoints without dwelling there: the step taken at an
    // endpoint already goes the new way.
    assign step_up = dir_up ? (dac_out != CODE_MAX) : (dac_out == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)             dir_up <= 1'b1;
        else if (tick && mode)  dir_up <= step_up;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            dac_out <= CODE_MID;
        else if (tick && mode)
            dac_out <= step_up ? dac_out + WIDTH'(1) : dac_out - WIDTH'(1);
        else if (pop)
            dac_out <= mem[rd_ptr];
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   dac_out <= CODE_MID;
        else if (pop) dac_out <= mem[rd_ptr];
    end
`endif

endmodule
